mc_refresh_sched: RTL
=====================

MC_REFRESH_SCHED -- requirements
Module: mc_refresh_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the refresh period and start configuration values.
REQ-002 SHALL have parameter MAX_PEND, default 8, the maximum number of postponed refreshes held.
REQ-003 SHALL have parameter URGENT_TH, default 6, the pending count at or above which refresh becomes urgent.
REQ-004 SHALL have port apb_clk  input  1  clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port apb_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mc_en  input  1  controller enable from the config block.
REQ-007 SHALL have port mc_refresh_period  input  DATA_WIDTH  number of cycles between refresh ticks.
REQ-008 SHALL have port mc_refresh_start  input  DATA_WIDTH  delay from enable to the first period; all-ones means refresh is disabled.
REQ-009 SHALL have port ref_ack  input  1  single-cycle pulse from the command FSM, asserted when it issues a refresh.
REQ-010 SHALL have port ref_req  output  1  at least one refresh is pending.
REQ-011 SHALL have port ref_urgent  output  1  pending count is at or above URGENT_TH.
REQ-012 SHALL have port ref_pending  output  $clog2(MAX_PEND+1)  current pending count.
REQ-013 SHALL have port ref_overflow  output  1  sticky flag: a tick arrived while pending was already MAX_PEND.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT_START and RUN.
REQ-015 SHALL go from any state to IDLE on the next edge whenever mc_en=0, clearing all counters, pending count and ref_overflow.
REQ-016 SHALL go from IDLE to WAIT_START when mc_en=1, with start_cnt set to 0.
REQ-017 In WAIT_START, SHALL increment start_cnt by 1 per cycle.
REQ-018 In WAIT_START, when start_cnt==mc_refresh_start, SHALL go to RUN with period_cnt set to 0.
REQ-019 SHALL hold WAIT_START indefinitely when mc_refresh_start is all-ones, and start_cnt SHALL saturate at all-ones minus 1.
REQ-020 In RUN, SHALL increment period_cnt each cycle; when period_cnt>=mc_refresh_period-1, it SHALL set period_cnt to 0 and generate one tick on that edge.
REQ-021 The >= comparison SHALL make a live decrease of the period take effect within one cycle.
REQ-022 mc_refresh_period==0 SHALL produce no ticks; period==1 SHALL produce one tick per cycle.
REQ-023 On a tick alone, pending SHALL increment by 1, saturating at MAX_PEND.
REQ-024 A tick arriving while pending==MAX_PEND SHALL set ref_overflow, which is cleared only by mc_en=0 or reset.
REQ-025 On ref_ack alone with pending>0, pending SHALL decrement by 1.
REQ-026 ref_ack with pending==0 SHALL be ignored.
REQ-027 A tick and ref_ack in the same cycle SHALL leave pending unchanged, except at MAX_PEND, where pending stays MAX_PEND and ref_overflow is not set.
REQ-028 ref_req SHALL equal (pending!=0), ref_urgent SHALL equal (pending>=URGENT_TH), and ref_pending SHALL equal pending; all three SHALL be registered values with no combinational path from ref_ack.
REQ-029 The first ref_req assertion SHALL occur exactly S+P+1 edges after the edge that first samples mc_en=1, where S=mc_refresh_start and P=mc_refresh_period.

Reset
REQ-030 While apb_rst_n=0, the state SHALL be IDLE, start_cnt=0, period_cnt=0, pending=0, ref_req=0, ref_urgent=0, ref_pending=0 and ref_overflow=0.
REQ-031 Reset assertion mid-RUN SHALL discard all pending refreshes immediately (asynchronously).

Structure
REQ-032 FSM state encodings and the all-ones "disabled" constant SHALL live in shared package mc_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the pending counter logic SHALL be inline.

Verification
REQ-034 Bench SHALL apply S=4, P=10, mc_en rising -> ref_req rises at edge 15 after enable; with no ack, pending=2 at edge 25.
REQ-035 Bench SHALL apply P=1 for 10 cycles with no ack -> pending saturates at 8, ref_urgent=1 from pending=6, and ref_overflow=1 after the 9th tick.
REQ-036 Bench SHALL assert ref_ack on the same cycle as a tick with pending=3 -> pending stays 3; a lone ack then gives 2.
REQ-037 Bench SHALL apply mc_refresh_start=32'hFFFF_FFFF with mc_en=1 for 1000 cycles -> ref_req stays 0 and the state stays WAIT_START.
REQ-038 Bench SHALL drop mc_en (or assert apb_rst_n=0) with pending=5 in RUN -> next edge (or immediately, for reset) pending=0, ref_req=0, ref_overflow=0, state IDLE.
REQ-039 Bench SHALL change P from 100 to 10 while period_cnt=50 -> a tick occurs on the next edge, then every 10 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg : shared FSM encodings and configuration constants for the
//          memory-controller refresh scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RUN        = 2'd2
  } mc_state_e;

  localparam int unsigned c_MAX_DATA_WIDTH = 64;

  // A start delay of all-ones parks the scheduler in WAIT_START forever.
  localparam logic [c_MAX_DATA_WIDTH-1:0] c_START_DISABLED = '1;

endpackage

`default_nettype wire

// File: rtl/mc_refresh_sched.sv
// ---------------------------------------------------------------------------
// mc_refresh_sched : periodic refresh tick generator with a saturating
//                    postponed-refresh counter and urgency/overflow flags.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_refresh_sched
  import mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_PEND   = 8,
  parameter int unsigned URGENT_TH  = 6
) (
  input  logic                            apb_clk,
  input  logic                            apb_rst_n,
  input  logic                            mc_en,
  input  logic [DATA_WIDTH-1:0]           mc_refresh_period,
  input  logic [DATA_WIDTH-1:0]           mc_refresh_start,
  input  logic                            ref_ack,
  output logic                            ref_req,
  output logic                            ref_urgent,
  output logic [$clog2(MAX_PEND+1)-1:0]   ref_pending,
  output logic                            ref_overflow
);

  localparam int unsigned           c_PW         = $clog2(MAX_PEND + 1);
  localparam logic [DATA_WIDTH-1:0] c_ONE        = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] c_START_OFF  = c_START_DISABLED[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] c_START_SAT  = c_START_OFF - c_ONE;
  localparam logic [c_PW-1:0]       c_PEND_MAX   = c_PW'(MAX_PEND);
  localparam logic [c_PW-1:0]       c_PEND_ONE   = c_PW'(1);

  mc_state_e             r_state;
  logic [DATA_WIDTH-1:0] r_start_cnt;
  logic [DATA_WIDTH-1:0] r_period_cnt;
  logic [c_PW-1:0]       r_pending;
  logic                  r_req;
  logic                  r_urgent;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_period_m1;
  logic                  w_tick;
  logic [c_PW-1:0]       w_pend_nxt;
  logic                  w_ovf_set;
  logic                  w_req_nxt;
  logic                  w_urgent_nxt;

  // Using >= rather than == lets a shortened period fire on the very next edge.
  always_comb begin
    w_period_m1 = mc_refresh_period - c_ONE;
    w_tick      = (r_state == ST_RUN) && (mc_refresh_period != '0) &&
                  (r_period_cnt >= w_period_m1);
  end

  always_comb begin
    w_pend_nxt = r_pending;
    w_ovf_set  = 1'b0;
    case ({w_tick, ref_ack})
      2'b10: begin
        if (r_pending == c_PEND_MAX) begin
          w_ovf_set = 1'b1;
        end else begin
          w_pend_nxt = r_pending + c_PEND_ONE;
        end
      end
      2'b01: begin
        if (r_pending != '0) begin
          w_pend_nxt = r_pending - c_PEND_ONE;
        end
      end
      default: w_pend_nxt = r_pending;
    endcase
    w_req_nxt    = (w_pend_nxt != '0);
    w_urgent_nxt = (32'(w_pend_nxt) >= 32'(URGENT_TH));
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_state      <= ST_IDLE;
      r_start_cnt  <= '0;
      r_period_cnt <= '0;
      r_pending    <= '0;
      r_req        <= 1'b0;
      r_urgent     <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (!mc_en) begin
      r_state      <= ST_IDLE;
      r_start_cnt  <= '0;
      r_period_cnt <= '0;
      r_pending    <= '0;
      r_req        <= 1'b0;
      r_urgent     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_req     <= w_req_nxt;
      r_urgent  <= w_urgent_nxt;
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_WAIT_START;
          r_start_cnt <= '0;
        end
        ST_WAIT_START: begin
          // Saturating one below all-ones keeps a disabled start from ever matching.
          if (r_start_cnt == mc_refresh_start) begin
            r_state      <= ST_RUN;
            r_period_cnt <= '0;
          end else if (r_start_cnt != c_START_SAT) begin
            r_start_cnt <= r_start_cnt + c_ONE;
          end
        end
        ST_RUN: begin
          if (w_tick || (mc_refresh_period == '0)) begin
            r_period_cnt <= '0;
          end else begin
            r_period_cnt <= r_period_cnt + c_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ref_req      = r_req;
  assign ref_urgent   = r_urgent;
  assign ref_pending  = r_pending;
  assign ref_overflow = r_overflow;

endmodule

`default_nettype wire
